sse_feeder: RTL and testbench

- Producer side of the SSE operand protocol: buffers (A,B) float32 pairs written by a host, then streams them into the SSE core on its `next` request.
- Asserts `stop` after the last pair, waits for `ready`, then captures the result Y.
- Sits between the host/config logic and the SSE core; it is the only driver of SSE's A, B, rst and stop.

---
 rtl/sse_pkg.sv | 28 ++
 rtl/sse_pair_buf.sv | 65 ++++++
 rtl/sse_feeder.sv | 248 ++++++++++++++++++++++++
 tb/tb_sse_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sse_pkg.sv
// sse_pkg: shared types and constants for the SSE operand feeder.
//   fp32_t          opaque 32-bit operand/result word
//   sse_pair_t      one (A,B) operand pair
//   feeder_state_t  feeder FSM encoding
//   FP32_*          handy single-precision constants
package sse_pkg;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } sse_pair_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

  localparam fp32_t FP32_ONE   = 32'h3F80_0000;
  localparam fp32_t FP32_TWO   = 32'h4000_0000;
  localparam fp32_t FP32_FOUR  = 32'h4080_0000;
  localparam fp32_t FP32_EIGHT = 32'h4100_0000;

endpackage

// File: rtl/sse_pair_buf.sv
// sse_pair_buf: DEPTH-entry register file of operand pairs, filled in order
// from entry 0, read back by index.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears fill state only)
//   wr_en_i         append wr_pair_i when not full (dropped when full)
//   wr_pair_i       pair to append
//   clr_i           empty the buffer (write pointer and count to 0)
//   rd_idx_i        combinational read index
//   rd_pair_o       pair at rd_idx_i
//   count_o         registered fill count
//   full_o          registered, high when count_o == DEPTH
module sse_pair_buf
  import sse_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  sse_pair_t        wr_pair_i,
  input  logic             clr_i,
  input  logic [PTR_W-1:0] rd_idx_i,
  output sse_pair_t        rd_pair_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  sse_pair_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full_q;
  logic             wr_ok;

  assign wr_ok = wr_en_i && !full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (wr_ok) begin
      wptr_q  <= wptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(1);
      full_q  <= (count_q == CNT_W'(DEPTH - 1));
    end
  end

  // Storage needs no reset: the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr_i) begin
      mem_q[wptr_q] <= wr_pair_i;
    end
  end

  assign rd_pair_o = mem_q[rd_idx_i];
  assign count_o   = count_q;
  assign full_o    = full_q;

endmodule

// File: rtl/sse_feeder.sv
// sse_feeder: buffers host-written (A,B) pairs and streams them into the SSE
// core, one pair per sse_next handshake; raises sse_stop after the last pair
// and captures sse_y on sse_ready.
// Optional: define SSE_FEEDER_TIMEOUT_EN to add parameter TIMEOUT and output
// timeout (watchdog on sse_next/sse_ready).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_en, wr_a, wr_b           host pair write (IDLE only)
//   full, count                 buffer status
//   start, busy, done, result   run control and captured Y
//   sse_rst, sse_a, sse_b,
//   sse_stop                    drive to the SSE core
//   sse_next, sse_ready, sse_y  handshake/result from the SSE core
//   timeout                     (optional) sticky watchdog flag
//
// state  | meaning
// IDLE   | SSE held in reset, host may fill the buffer
// LOAD   | present entry 0, SSE still in reset
// STREAM | SSE running, advance pair on each sse_next
// DRAIN  | sse_stop high, wait for sse_ready
// DONE   | result captured, clear buffer, back to IDLE
module sse_feeder
  import sse_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
`ifdef SSE_FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              sse_rst,
  output logic [DATA_W-1:0] sse_a,
  output logic [DATA_W-1:0] sse_b,
  output logic              sse_stop,
  input  logic              sse_next,
  input  logic              sse_ready,
  input  logic [DATA_W-1:0] sse_y
`ifdef SSE_FEEDER_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  feeder_state_t     state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              sse_rst_q, sse_rst_d;
  logic [DATA_W-1:0] sse_a_q, sse_a_d;
  logic [DATA_W-1:0] sse_b_q, sse_b_d;
  logic              sse_stop_q, sse_stop_d;

  logic              buf_wr;
  logic              buf_clr;
  logic [PTR_W-1:0]  rd_idx;
  sse_pair_t         wr_pair;
  sse_pair_t         rd_pair;

`ifdef SSE_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;
  logic            tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TO_W'(TIMEOUT - 1));
`endif

  // Writes are only taken while idle; a write in the start cycle still lands.
  assign buf_wr       = wr_en && (state_q == IDLE);
  assign wr_pair.a    = fp32_t'(wr_a);
  assign wr_pair.b    = fp32_t'(wr_b);
  // Look one entry ahead while streaming so the next pair registers on sse_next.
  assign rd_idx       = (state_q == STREAM) ? rd_ptr_q + PTR_W'(1) : '0;

  sse_pair_buf #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (buf_wr),
    .wr_pair_i (wr_pair),
    .clr_i     (buf_clr),
    .rd_idx_i  (rd_idx),
    .rd_pair_o (rd_pair),
    .count_o   (count),
    .full_o    (full)
  );

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    sse_rst_d  = sse_rst_q;
    sse_a_d    = sse_a_q;
    sse_b_d    = sse_b_q;
    sse_stop_d = sse_stop_q;
    buf_clr    = 1'b0;
`ifdef SSE_FEEDER_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        sse_rst_d = 1'b1;
        if (start && (count != '0)) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          // Stream length is frozen from the pre-write count.
          last_d  = PTR_W'(count - CNT_W'(1));
`ifdef SSE_FEEDER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        sse_rst_d = 1'b1;
        sse_a_d   = DATA_W'(rd_pair.a);
        sse_b_d   = DATA_W'(rd_pair.b);
        rd_ptr_d  = '0;
        state_d   = STREAM;
`ifdef SSE_FEEDER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      STREAM: begin
        sse_rst_d = 1'b0;
        if (sse_next) begin
`ifdef SSE_FEEDER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (rd_ptr_q != last_q) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            sse_a_d  = DATA_W'(rd_pair.a);
            sse_b_d  = DATA_W'(rd_pair.b);
          end else begin
            sse_stop_d = 1'b1;
            state_d    = DRAIN;
          end
        end
`ifdef SSE_FEEDER_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TO_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (sse_ready) begin
          result_d = sse_y;
          done_d   = 1'b1;
          state_d  = DONE;
`ifdef SSE_FEEDER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
`ifdef SSE_FEEDER_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TO_W'(1);
        end
`endif
      end
      DONE: begin
        buf_clr    = 1'b1;
        busy_d     = 1'b0;
        sse_stop_d = 1'b0;
        sse_rst_d  = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      last_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      sse_rst_q  <= 1'b1;
      sse_a_q    <= '0;
      sse_b_q    <= '0;
      sse_stop_q <= 1'b0;
`ifdef SSE_FEEDER_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      sse_rst_q  <= sse_rst_d;
      sse_a_q    <= sse_a_d;
      sse_b_q    <= sse_b_d;
      sse_stop_q <= sse_stop_d;
`ifdef SSE_FEEDER_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign sse_rst  = sse_rst_q;
  assign sse_a    = sse_a_q;
  assign sse_b    = sse_b_q;
  assign sse_stop = sse_stop_q;
`ifdef SSE_FEEDER_TIMEOUT_EN
  assign timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_sse_feeder.sv
// tb_sse_feeder: directed bench for sse_feeder; the SSE core is played by
// hand-driven sse_next/sse_ready/sse_y.
module tb_sse_feeder;
  import sse_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_a = '0;
  logic [DATA_W-1:0] wr_b = '0;
  logic              start = 1'b0;
  logic              sse_next = 1'b0;
  logic              sse_ready = 1'b0;
  logic [DATA_W-1:0] sse_y = '0;
  logic              full, busy, done, sse_rst, sse_stop;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] result, sse_a, sse_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef SSE_FEEDER_TIMEOUT_EN
  logic timeout;
  sse_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
    .full(full), .count(count), .start(start), .busy(busy), .done(done),
    .result(result), .sse_rst(sse_rst), .sse_a(sse_a), .sse_b(sse_b),
    .sse_stop(sse_stop), .sse_next(sse_next), .sse_ready(sse_ready),
    .sse_y(sse_y), .timeout(timeout)
  );
`else
  sse_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
    .full(full), .count(count), .start(start), .busy(busy), .done(done),
    .result(result), .sse_rst(sse_rst), .sse_a(sse_a), .sse_b(sse_b),
    .sse_stop(sse_stop), .sse_next(sse_next), .sse_ready(sse_ready),
    .sse_y(sse_y)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    wr_en = 1'b1;
    wr_a  = a;
    wr_b  = b;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    // reset values
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_sse_rst", 64'(sse_rst), 64'd1);
    chk("rst_sse_a", 64'(sse_a), 64'd0);
    chk("rst_sse_b", 64'(sse_b), 64'd0);
    chk("rst_stop", 64'(sse_stop), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    rst_n = 1'b1;
    tick();

    // two pairs, next every 3rd cycle
    push(FP32_FOUR, FP32_TWO);
    push(FP32_EIGHT, FP32_FOUR);
    chk("t1_count", 64'(count), 64'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_load_rst", 64'(sse_rst), 64'd1);
    tick();
    chk("t1_p0_a", 64'(sse_a), 64'h4080_0000);
    chk("t1_p0_b", 64'(sse_b), 64'h4000_0000);
    chk("t1_p0_rst", 64'(sse_rst), 64'd1);
    tick();
    chk("t1_run_rst", 64'(sse_rst), 64'd0);
    tick();
    sse_next = 1'b1;
    tick();
    sse_next = 1'b0;
    chk("t1_p1_a", 64'(sse_a), 64'h4100_0000);
    chk("t1_p1_b", 64'(sse_b), 64'h4080_0000);
    chk("t1_stop_lo", 64'(sse_stop), 64'd0);
    tick();
    tick();
    sse_next = 1'b1;
    tick();
    sse_next = 1'b0;
    chk("t1_stop_hi", 64'(sse_stop), 64'd1);
    sse_ready = 1'b1;
    sse_y = 32'h41A0_0000;
    tick();
    sse_ready = 1'b0;
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_result", 64'(result), 64'h41A0_0000);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_busy_lo", 64'(busy), 64'd0);
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_stop_clr", 64'(sse_stop), 64'd0);
    chk("t1_idle_rst", 64'(sse_rst), 64'd1);

    // 17 writes into 16 entries, then full stream; ready alongside first next
    for (int i = 0; i < 17; i++) begin
      push(32'(i), 32'(i + 256));
      if (i == 14) chk("t2_not_full", 64'(full), 64'd0);
      if (i == 15) chk("t2_full", 64'(full), 64'd1);
    end
    chk("t2_count", 64'(count), 64'd16);
    chk("t2_full_kept", 64'(full), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("t2_a", 64'(sse_a), 64'(k));
      chk("t2_b", 64'(sse_b), 64'(k + 256));
      chk("t2_stop_lo", 64'(sse_stop), 64'd0);
      sse_next = 1'b1;
      if (k == 0) begin
        sse_ready = 1'b1;
        sse_y = 32'hDEAD_BEEF;
      end
      tick();
      sse_next = 1'b0;
      sse_ready = 1'b0;
    end
    chk("t2_stop_hi", 64'(sse_stop), 64'd1);
    chk("t2_result_held", 64'(result), 64'h41A0_0000);
    sse_ready = 1'b1;
    sse_y = 32'h4150_0000;
    tick();
    sse_ready = 1'b0;
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_result", 64'(result), 64'h4150_0000);
    tick();

    // start ignored when empty and while busy
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_empty_busy", 64'(busy), 64'd0);
    chk("t3_empty_rst", 64'(sse_rst), 64'd1);
    tick();
    chk("t3_empty_busy2", 64'(busy), 64'd0);
    push(FP32_ONE, FP32_TWO);
    push(FP32_TWO, FP32_ONE);
    start = 1'b1;
    tick();
    chk("t3_busy", 64'(busy), 64'd1);
    tick();
    chk("t3_p0_a", 64'(sse_a), 64'h3F80_0000);
    tick();
    start = 1'b0;
    chk("t3_busy_hold", 64'(busy), 64'd1);
    chk("t3_run_rst", 64'(sse_rst), 64'd0);
    chk("t3_p0_hold", 64'(sse_a), 64'h3F80_0000);
    sse_next = 1'b1;
    tick();
    sse_next = 1'b0;
    chk("t3_p1_a", 64'(sse_a), 64'h4000_0000);

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_sse_rst", 64'(sse_rst), 64'd1);
    chk("t4_sse_a", 64'(sse_a), 64'd0);
    chk("t4_sse_b", 64'(sse_b), 64'd0);
    chk("t4_stop", 64'(sse_stop), 64'd0);
    chk("t4_result", 64'(result), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // write in the start cycle: accepted, but not streamed
    push(FP32_EIGHT, FP32_ONE);
    wr_en = 1'b1;
    wr_a = FP32_FOUR;
    wr_b = FP32_TWO;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("t5_count", 64'(count), 64'd2);
    chk("t5_busy", 64'(busy), 64'd1);
    tick();
    chk("t5_p0_a", 64'(sse_a), 64'h4100_0000);
    chk("t5_p0_b", 64'(sse_b), 64'h3F80_0000);
    tick();
    chk("t5_run_rst", 64'(sse_rst), 64'd0);
    sse_next = 1'b1;
    tick();
    sse_next = 1'b0;
    chk("t5_stop", 64'(sse_stop), 64'd1);
    chk("t5_a_held", 64'(sse_a), 64'h4100_0000);
    sse_ready = 1'b1;
    sse_y = FP32_ONE;
    tick();
    sse_ready = 1'b0;
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_result", 64'(result), 64'h3F80_0000);
    tick();
    chk("t5_count0", 64'(count), 64'd0);
    chk("t5_busy_lo", 64'(busy), 64'd0);

`ifdef SSE_FEEDER_TIMEOUT_EN
    // watchdog in DRAIN: ready never arrives
    begin
      int n;
      push(FP32_TWO, FP32_TWO);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      sse_next = 1'b1;
      tick();
      sse_next = 1'b0;
      chk("t6_stop", 64'(sse_stop), 64'd1);
      n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      chk("t6_cycles", 64'(n), 64'd8);
      chk("t6_timeout", 64'(timeout), 64'd1);
      chk("t6_result", 64'(result), 64'h3F80_0000);
      tick();
      chk("t6_busy_lo", 64'(busy), 64'd0);
      chk("t6_sticky", 64'(timeout), 64'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
